// File: rtl/fm_demod_pkg.sv
// Shared types and default settings for the FM demodulator supervisor.
package fm_demod_pkg;

  // Gap-measurement sequencer states
  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2,
    S_TRACK = 2'd3
  } state_e;

  localparam int DEF_DATA_W     = 10;
  localparam int DEF_LOW_TH     = 80;
  localparam int DEF_HIGH_TH    = 950;
  localparam int DEF_HOLDOFF    = 400;
  localparam int DEF_MUTE_VAL   = 200;
  localparam int DEF_CNT_W      = 14;
  localparam int DEF_HIST_DEPTH = 16;

endpackage

// File: rtl/fm_demod_supervisor_if.sv
// Sample, audio, gap-period and history-read signals of the supervisor.
interface fm_demod_supervisor_if #(
  parameter int DATA_W     = fm_demod_pkg::DEF_DATA_W,
  parameter int CNT_W      = fm_demod_pkg::DEF_CNT_W,
  parameter int HIST_DEPTH = fm_demod_pkg::DEF_HIST_DEPTH
);
  localparam int HC_W = $clog2(HIST_DEPTH) + 1;

  logic [DATA_W-1:0] demod_data;
  logic              demod_valid;
  logic [DATA_W-1:0] audio_out;
  logic              audio_valid;
  logic              mute;
  logic [CNT_W-1:0]  rb_period;
  logic              rb_valid;
  logic              rb_ovf;
  logic              hist_rd_en;
  logic [DATA_W-1:0] hist_rd_data;
  logic              hist_rd_vld;
  logic [HC_W-1:0]   hist_count;
  logic              hist_ovf;

  // Sample source / host side
  modport master (
    output demod_data, demod_valid, hist_rd_en,
    input  audio_out, audio_valid, mute, rb_period, rb_valid, rb_ovf,
           hist_rd_data, hist_rd_vld, hist_count, hist_ovf
  );

  // Supervisor side
  modport slave (
    input  demod_data, demod_valid, hist_rd_en,
    output audio_out, audio_valid, mute, rb_period, rb_valid, rb_ovf,
           hist_rd_data, hist_rd_vld, hist_count, hist_ovf
  );
endinterface

// File: rtl/fm_hist_fifo.sv
// Synchronous history FIFO; registered read data presented one cycle after a pop.
module fm_hist_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_vld_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              rd_vld_q;
  logic              pop_ok, push_ok;

  assign full_o  = (count_q == FULL_C);
  assign empty_o = (count_q == '0);
  // A pop frees a slot in the same cycle, so push+pop on a full FIFO both proceed
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Occupancy update from accepted push/pop
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage and read data register (data only, not reset)
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
    if (pop_ok)  rd_data_q       <= mem_q[rd_ptr_q];
  end

  // Pointers, count and read-valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q  <= count_d;
      rd_vld_q <= pop_ok;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_vld_o  = rd_vld_q;
  assign count_o   = count_q;
endmodule

// File: rtl/fm_demod_supervisor.sv
// FM demod supervisor: range squelch with hold-off, gap-period measurement,
// and capture of in-range samples into a host-readable history FIFO.
module fm_demod_supervisor
  import fm_demod_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOW_TH     = DEF_LOW_TH,
  parameter int HIGH_TH    = DEF_HIGH_TH,
  parameter int HOLDOFF    = DEF_HOLDOFF,
  parameter int MUTE_VAL   = DEF_MUTE_VAL,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HIST_DEPTH = DEF_HIST_DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  fm_demod_supervisor_if.slave bus
);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int HC_W   = $clog2(HIST_DEPTH) + 1;

  localparam logic [DATA_W-1:0] LOW_C     = DATA_W'(LOW_TH);
  localparam logic [DATA_W-1:0] HIGH_C    = DATA_W'(HIGH_TH);
  localparam logic [DATA_W-1:0] MUTE_C    = DATA_W'(MUTE_VAL);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Saturating increment; MSB flags that the counter was already at its ceiling
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return {1'b1, v};
    return {1'b0, v + CNT_ONE};
  endfunction

  logic              oor, inr, rise, fall;
  logic              mute_q, mute_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] audio_q;
  logic              audio_vld_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rb_period_q, rb_period_d;
  logic              rb_valid_q, rb_valid_d;
  logic              rb_ovf_q, rb_ovf_d;
  logic [CNT_W:0]    cnt_inc;
  logic              hist_push;
  logic              hist_ovf_q, hist_ovf_d;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic [HC_W-1:0]   fifo_count;

  // Range qualification; idle cycles produce neither event
  assign oor  = bus.demod_valid && ((bus.demod_data < LOW_C) || (bus.demod_data > HIGH_C));
  assign inr  = bus.demod_valid && !oor;
  // Mute edges as decided by the current sample
  assign rise = oor && !mute_q;
  assign fall = inr && mute_q && (hold_q == '0);

  // Squelch: any out-of-range sample re-arms the hold-off; unmute on the sample finding it at zero
  always_comb begin
    mute_d = mute_q;
    hold_d = hold_q;
    if (oor) begin
      mute_d = 1'b1;
      hold_d = HOLD_INIT;
    end else if (inr && mute_q) begin
      if (hold_q == '0) mute_d = 1'b0;
      else              hold_d = hold_q - HOLD_ONE;
    end
  end

  // Mute state and hold-off register
  always_ff @(posedge clk) begin
    if (rst) begin
      mute_q <= 1'b1;
      hold_q <= HOLD_INIT;
    end else begin
      mute_q <= mute_d;
      hold_q <= hold_d;
    end
  end

  // Audio register: uses the mute state seen before this sample
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_q     <= MUTE_C;
      audio_vld_q <= 1'b0;
    end else begin
      audio_vld_q <= bus.demod_valid;
      if (bus.demod_valid) audio_q <= mute_q ? MUTE_C : bus.demod_data;
    end
  end

  assign cnt_inc = sat_inc(cnt_q);

  // Gap-period sequencer next state; captures in-range samples while tracking
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rb_period_d = rb_period_q;
    rb_valid_d  = 1'b0;
    rb_ovf_d    = rb_ovf_q;
    hist_push   = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (rise) begin
          state_d = S_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      S_COUNT: begin
        if (fall) begin
          state_d = S_LATCH;
        end else if (bus.demod_valid) begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc[CNT_W]) rb_ovf_d = 1'b1;
        end
      end
      S_LATCH: begin
        rb_period_d = cnt_q;
        rb_valid_d  = 1'b1;
        state_d     = S_TRACK;
      end
      S_TRACK: begin
        if (rise) begin
          state_d = S_COUNT;
          cnt_d   = CNT_ONE;
        end else if (inr) begin
          hist_push = 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Sequencer and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      rb_period_q <= '0;
      rb_valid_q  <= 1'b0;
      rb_ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rb_period_q <= rb_period_d;
      rb_valid_q  <= rb_valid_d;
      rb_ovf_q    <= rb_ovf_d;
    end
  end

  // A push is dropped only when full and no pop frees a slot this cycle
  assign hist_ovf_d = hist_ovf_q | (hist_push && fifo_full && !(bus.hist_rd_en && !fifo_empty));

  // Sticky history overflow flag
  always_ff @(posedge clk) begin
    if (rst) hist_ovf_q <= 1'b0;
    else     hist_ovf_q <= hist_ovf_d;
  end

  fm_hist_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .push_i    (hist_push),
    .data_i    (bus.demod_data),
    .pop_i     (bus.hist_rd_en),
    .rd_data_o (fifo_rd_data),
    .rd_vld_o  (fifo_rd_vld),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bus.audio_out    = audio_q;
  assign bus.audio_valid  = audio_vld_q;
  assign bus.mute         = mute_q;
  assign bus.rb_period    = rb_period_q;
  assign bus.rb_valid     = rb_valid_q;
  assign bus.rb_ovf       = rb_ovf_q;
  assign bus.hist_rd_data = fifo_rd_data;
  assign bus.hist_rd_vld  = fifo_rd_vld;
  assign bus.hist_count   = fifo_count;
  assign bus.hist_ovf     = hist_ovf_q;
endmodule
